// File: rtl/alu_req_sequencer.sv
// Request/response sequencer in front of a multi-cycle ALU: registers one request,
// holds the ALU drive for the command's latency, captures the result and waits for the consumer.
module alu_req_sequencer #(
  parameter int WIDTH   = 8,
  parameter int LAT     = 1,
  parameter int MUL_LAT = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               REQ_VALID,
  output logic               REQ_READY,
  input  logic [WIDTH-1:0]   REQ_OPA,
  input  logic [WIDTH-1:0]   REQ_OPB,
  input  logic [3:0]         REQ_CMD,
  input  logic               REQ_MODE,
  input  logic               REQ_CIN,
  input  logic [1:0]         REQ_INP_VALID,
  output logic               CE,
  output logic [WIDTH-1:0]   OPA,
  output logic [WIDTH-1:0]   OPB,
  output logic [3:0]         CMD,
  output logic               MODE,
  output logic               CIN,
  output logic [1:0]         INP_VALID,
  input  logic [2*WIDTH-1:0] RES,
  input  logic               COUT,
  input  logic               OFLOW,
  input  logic               G,
  input  logic               E,
  input  logic               L,
  input  logic               ERR,
  output logic               RSP_VALID,
  input  logic               RSP_READY,
  output logic [2*WIDTH-1:0] RSP_RES,
  output logic [5:0]         RSP_FLAGS,
  output logic [15:0]        TXN_CNT
);

  localparam int MAX_LAT = (LAT > MUL_LAT) ? LAT : MUL_LAT;
  localparam int CW      = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state;
  state_t        state_next;
  logic [1:0]    rst_sync;
  logic          rst_n;
  logic [CW-1:0] lat_cnt;
  logic          is_mul;

  // Reset asserts asynchronously but releases two edges later, so the
  // first acceptance cannot coincide with the edge that lifts RST.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) rst_sync <= '0;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign is_mul    = REQ_MODE && ((REQ_CMD == 4'd9) || (REQ_CMD == 4'd10));
  assign REQ_READY = (state == IDLE);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (REQ_VALID) state_next = (REQ_INP_VALID != 2'b00) ? BUSY : RESP;
      BUSY: if (lat_cnt == '0) state_next = RESP;
      RESP: if (RSP_READY) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      CE        <= 1'b0;
      OPA       <= '0;
      OPB       <= '0;
      CMD       <= '0;
      MODE      <= 1'b0;
      CIN       <= 1'b0;
      INP_VALID <= '0;
      lat_cnt   <= '0;
      RSP_VALID <= 1'b0;
      RSP_RES   <= '0;
      RSP_FLAGS <= '0;
      TXN_CNT   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (REQ_VALID) begin
            if (REQ_INP_VALID != 2'b00) begin
              OPA       <= REQ_OPA;
              OPB       <= REQ_OPB;
              CMD       <= REQ_CMD;
              MODE      <= REQ_MODE;
              CIN       <= REQ_CIN;
              INP_VALID <= REQ_INP_VALID;
              CE        <= 1'b1;
              lat_cnt   <= is_mul ? CW'(MUL_LAT) : CW'(LAT);
            end else begin
              // No operands: answer locally without waking the ALU.
              RSP_RES   <= '0;
              RSP_FLAGS <= 6'b000001;
              RSP_VALID <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - CW'(1);
          end else begin
            RSP_RES   <= RES;
            RSP_FLAGS <= {COUT, OFLOW, G, E, L, ERR};
            RSP_VALID <= 1'b1;
            CE        <= 1'b0;
          end
        end
        RESP: begin
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            TXN_CNT   <= TXN_CNT + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_sequencer.sv
// Scoreboard bench for alu_req_sequencer with a latency-aware stand-in ALU
// that returns garbage until CE has been held for the command's full latency.
module tb_alu_req_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic [7:0]  REQ_OPA = '0;
  logic [7:0]  REQ_OPB = '0;
  logic [3:0]  REQ_CMD = '0;
  logic        REQ_MODE = 1'b0;
  logic        REQ_CIN = 1'b0;
  logic [1:0]  REQ_INP_VALID = '0;
  logic        CE;
  logic [7:0]  OPA;
  logic [7:0]  OPB;
  logic [3:0]  CMD;
  logic        MODE;
  logic        CIN;
  logic [1:0]  INP_VALID;
  logic [15:0] RES;
  logic        COUT, OFLOW, G, E, L, ERR;
  logic        RSP_VALID;
  logic        RSP_READY = 1'b1;
  logic [15:0] RSP_RES;
  logic [5:0]  RSP_FLAGS;
  logic [15:0] TXN_CNT;

  int          vec = 0;
  int          errs = 0;
  logic        bulk = 1'b0;
  logic [21:0] sb[$];
  logic [15:0] exp_txn = '0;

  alu_req_sequencer #(.WIDTH(8), .LAT(1), .MUL_LAT(2)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_OPA(REQ_OPA), .REQ_OPB(REQ_OPB), .REQ_CMD(REQ_CMD),
    .REQ_MODE(REQ_MODE), .REQ_CIN(REQ_CIN), .REQ_INP_VALID(REQ_INP_VALID),
    .CE(CE), .OPA(OPA), .OPB(OPB), .CMD(CMD), .MODE(MODE), .CIN(CIN),
    .INP_VALID(INP_VALID),
    .RES(RES), .COUT(COUT), .OFLOW(OFLOW), .G(G), .E(E), .L(L), .ERR(ERR),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_RES(RSP_RES), .RSP_FLAGS(RSP_FLAGS), .TXN_CNT(TXN_CNT)
  );

  always #5 CLK = ~CLK;

  // Stand-in ALU: result is only meaningful after CE has been sampled for the full latency.
  logic [3:0] alu_age = '0;
  always @(posedge CLK) begin
    if (!CE)                 alu_age <= '0;
    else if (alu_age != 4'hF) alu_age <= alu_age + 4'd1;
  end

  logic       alu_mul;
  logic [8:0] alu_sum;
  always_comb begin
    alu_mul = MODE && ((CMD == 4'd9) || (CMD == 4'd10));
    alu_sum = {1'b0, OPA} + {1'b0, OPB} + {8'd0, CIN};
    RES = 16'hDEAD;
    {COUT, OFLOW, G, E, L, ERR} = 6'b111111;
    if (alu_age >= (alu_mul ? 4'd2 : 4'd1)) begin
      if (alu_mul)            RES = {8'd0, OPA} * {8'd0, OPB};
      else if (CMD == 4'd0)   RES = {7'd0, alu_sum};
      else                    RES = {8'd0, OPA ^ OPB};
      COUT  = (!alu_mul && CMD == 4'd0) ? alu_sum[8] : 1'b0;
      OFLOW = 1'b0;
      G     = OPA > OPB;
      E     = OPA == OPB;
      L     = OPA < OPB;
      ERR   = CMD > 4'd13;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!bulk && RST && RSP_VALID && RSP_READY) begin
      if (sb.size() == 0) begin
        vec++;
        errs++;
        $display("FAIL unexpected_rsp: got res %0h flags %0h expected no response", RSP_RES, RSP_FLAGS);
      end else begin
        logic [21:0] e;
        e = sb.pop_front();
        check("rsp_res", 32'(RSP_RES), 32'(e[21:6]));
        check("rsp_flags", 32'(RSP_FLAGS), 32'(e[5:0]));
      end
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (!REQ_READY && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    if (!REQ_READY) check({name, "_ready_timeout"}, 32'(REQ_READY), 32'd1);
  endtask

  task automatic send(input logic m, input logic [3:0] c, input logic [7:0] a, input logic [7:0] b,
                      input logic ci, input logic [1:0] iv, input logic [15:0] er,
                      input logic [5:0] ef, input int el);
    int lat = 0;
    wait_ready("send");
    check("txn_cnt", 32'(TXN_CNT), 32'(exp_txn));
    REQ_MODE = m; REQ_CMD = c; REQ_OPA = a; REQ_OPB = b; REQ_CIN = ci; REQ_INP_VALID = iv;
    REQ_VALID = 1'b1;
    sb.push_back({er, ef});
    exp_txn = exp_txn + 16'd1;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    check("ce_after_accept", 32'(CE), 32'(iv != 2'b00));
    while (!RSP_VALID && lat < 20) begin
      @(posedge CLK); #1;
      lat++;
    end
    check("rsp_latency", 32'(lat), 32'(el));
    check("ce_in_resp", 32'(CE), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_ctrl", 32'({CE, MODE, CIN, INP_VALID, RSP_VALID, RSP_FLAGS, REQ_READY}), 32'd1);
    check("rst_ops", 32'({OPA, OPB, CMD}), 32'd0);
    check("rst_res_txn", {RSP_RES, TXN_CNT}, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;

    //   mode  cmd    opa    opb    cin  inp    res        flags      lat
    send(1'b1, 4'd0,  8'h0F, 8'h01, 1'b0, 2'b11, 16'h0010, 6'b001000, 2);
    wait_ready("add");
    check("txn_after_add", 32'(TXN_CNT), 32'd1);
    send(1'b1, 4'd9,  8'h03, 8'h04, 1'b0, 2'b11, 16'h000C, 6'b000010, 3);
    send(1'b1, 4'd0,  8'hFF, 8'h01, 1'b0, 2'b11, 16'h0100, 6'b101000, 2);
    send(1'b1, 4'd10, 8'h10, 8'h10, 1'b0, 2'b11, 16'h0100, 6'b000100, 3);
    send(1'b0, 4'd9,  8'hAA, 8'h55, 1'b0, 2'b01, 16'h00FF, 6'b001000, 2);
    send(1'b1, 4'd15, 8'h01, 8'h02, 1'b0, 2'b10, 16'h0003, 6'b000011, 2);
    send(1'b1, 4'd0,  8'h12, 8'h34, 1'b0, 2'b00, 16'h0000, 6'b000001, 0);
    send(1'b1, 4'd0,  8'h80, 8'h7F, 1'b1, 2'b11, 16'h0100, 6'b101000, 2);

    // Backpressure with a second request already waiting.
    wait_ready("bp");
    RSP_READY = 1'b0;
    REQ_MODE = 1'b1; REQ_CMD = 4'd0; REQ_OPA = 8'h22; REQ_OPB = 8'h11; REQ_CIN = 1'b0;
    REQ_INP_VALID = 2'b11; REQ_VALID = 1'b1;
    sb.push_back({16'h0033, 6'b001000});
    @(posedge CLK); #1;
    REQ_OPA = 8'h05; REQ_OPB = 8'h05;
    begin
      int n = 0;
      while (!RSP_VALID && n < 20) begin
        @(posedge CLK); #1;
        n++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      check("bp_hold", 32'({RSP_VALID, REQ_READY, CE, RSP_FLAGS, RSP_RES}),
            32'({1'b1, 1'b0, 1'b0, 6'b001000, 16'h0033}));
    end
    RSP_READY = 1'b1;
    sb.push_back({16'h000A, 6'b000100});
    @(posedge CLK); #1;
    check("bp_release", 32'({REQ_READY, RSP_VALID, CE}), 32'b100);
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    check("bp_next_accept", 32'({CE, OPA}), 32'({1'b1, 8'h05}));
    exp_txn = exp_txn + 16'd2;
    begin
      int n = 0;
      while (!RSP_VALID && n < 20) begin
        @(posedge CLK); #1;
        n++;
      end
    end

    // Reset while BUSY discards the transaction.
    wait_ready("rst_busy");
    check("txn_before_rst", 32'(TXN_CNT), 32'(exp_txn));
    REQ_MODE = 1'b1; REQ_CMD = 4'd9; REQ_OPA = 8'h07; REQ_OPB = 8'h07; REQ_INP_VALID = 2'b11;
    REQ_VALID = 1'b1;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    @(posedge CLK); #2;
    RST = 1'b0;
    #1;
    check("rst_busy_ctrl", 32'({CE, RSP_VALID, REQ_READY, TXN_CNT, OPA}), 32'({1'b0, 1'b0, 1'b1, 16'h0000, 8'h00}));
    exp_txn = '0;
    REQ_INP_VALID = 2'b00;
    REQ_VALID = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    check("rst_sync_no_accept", 32'({RSP_VALID, CE}), 32'd0);
    REQ_VALID = 1'b0;
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(posedge CLK); #1;
        if (RSP_VALID) seen = 1'b1;
      end
      check("no_rsp_after_rst", 32'({seen, TXN_CNT}), 32'd0);
    end

    // Wrap: 65535 back-to-back local-error transactions, then one checked transaction.
    wait_ready("bulk");
    bulk = 1'b1;
    REQ_INP_VALID = 2'b00;
    REQ_VALID = 1'b1;
    RSP_READY = 1'b1;
    repeat (131070) @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;
    bulk = 1'b0;
    check("txn_ffff", 32'(TXN_CNT), 32'h0000FFFF);
    exp_txn = 16'hFFFF;
    send(1'b1, 4'd0, 8'h01, 8'h01, 1'b1, 2'b11, 16'h0003, 6'b000100, 2);
    wait_ready("wrap");
    check("txn_wrap", 32'(TXN_CNT), 32'h00000000);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/alu_req_sequencer.md
ALU_REQ_SEQUENCER -- requirements
Module: alu_req_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width; ALU RES width is 2*WIDTH.
REQ-002 SHALL have parameter LAT, default 1, ALU result latency in clock edges for non-multiply commands.
REQ-003 SHALL have parameter MUL_LAT, default 2, ALU result latency in clock edges for MODE=1, CMD=9 or 10.
REQ-004 SHALL have port CLK, input, 1, sole clock, rising edge.
REQ-005 SHALL have port RST, input, 1, asynchronous active-low reset.
REQ-006 SHALL have REQ_VALID in 1 / REQ_READY out 1: request handshake.
REQ-007 SHALL have REQ_OPA, REQ_OPB in WIDTH; REQ_CMD in 4; REQ_MODE in 1; REQ_CIN in 1; REQ_INP_VALID in 2: request payload.
REQ-008 SHALL have CE out 1; OPA, OPB out WIDTH; CMD out 4; MODE out 1; CIN out 1; INP_VALID out 2: ALU drive side.
REQ-009 SHALL have RES in 2*WIDTH; COUT, OFLOW, G, E, L, ERR in 1 each: ALU result side.
REQ-010 SHALL have RSP_VALID out 1 / RSP_READY in 1: response handshake.
REQ-011 SHALL have RSP_RES out 2*WIDTH; RSP_FLAGS out 6, ordered {COUT,OFLOW,G,E,L,ERR}: response payload.
REQ-012 SHALL have TXN_CNT out 16: completed-transaction count.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, RESP; REQ_READY SHALL be 1 only in IDLE (decoded from state).
REQ-014 In IDLE, on REQ_VALID=1 at a rising edge with REQ_INP_VALID!=0, SHALL register payload onto OPA/OPB/CMD/MODE/CIN/INP_VALID, set CE=1, load latency counter with MUL_LAT if REQ_MODE=1 and REQ_CMD is 9 or 10, else LAT, and enter BUSY.
REQ-015 In BUSY, ALU drive outputs SHALL hold stable with CE=1; counter SHALL decrement each edge while nonzero.
REQ-016 In BUSY, at the edge where counter==0, SHALL capture RES into RSP_RES and the flags into RSP_FLAGS, set CE=0, set RSP_VALID=1, and enter RESP; RSP_VALID therefore rises latency+1 edges after the acceptance edge.
REQ-017 In IDLE, on REQ_VALID=1 with REQ_INP_VALID=00, SHALL keep CE=0, enter RESP on that edge with RSP_RES=0 and RSP_FLAGS=6'b000001 (local ERR only).
REQ-018 In RESP, RSP_VALID, RSP_RES and RSP_FLAGS SHALL hold stable until RSP_READY=1 at an edge; on that edge SHALL clear RSP_VALID, increment TXN_CNT, and enter IDLE.
REQ-019 Throughput: no new request SHALL be accepted in the edge that completes a response (REQ_READY is 0 in RESP).
REQ-020 TXN_CNT SHALL wrap from 16'hFFFF to 16'h0000 without flagging.
REQ-021 CMD/MODE values SHALL be forwarded unfiltered; illegal-command detection is the ALU's ERR output.
REQ-022 CE SHALL be 0 in IDLE and RESP so the ALU holds its outputs.

Reset
REQ-023 On RST=0 all registered outputs SHALL clear immediately: CE=0, OPA=OPB=0, CMD=0, MODE=0, CIN=0, INP_VALID=0, RSP_VALID=0, RSP_RES=0, RSP_FLAGS=0, TXN_CNT=0, state=IDLE (REQ_READY=1).
REQ-024 Reset asserted in BUSY or RESP SHALL discard the in-flight transaction without a response or TXN_CNT increment.
REQ-025 Reset deassertion SHALL be synchronised so the first acceptance occurs no earlier than the second rising edge after RST rises.

Verification
REQ-026 Reset: assert RST=0 during BUSY -> CE=0, RSP_VALID=0, TXN_CNT=0 immediately, REQ_READY=1; no response appears after release.
REQ-027 Add: MODE=1, CMD=0, OPA=8'h0F, OPB=8'h01, INP_VALID=11, RSP_READY=1 -> CE=1 for 2 cycles, RSP_VALID rises 2 edges after acceptance, RSP_RES=16'h0010, TXN_CNT=1.
REQ-028 Multiply: MODE=1, CMD=9, OPA=3, OPB=4 -> RSP_VALID rises 3 edges after acceptance; RSP_RES equals the RES value at the capture edge.
REQ-029 Invalid: INP_VALID=00 -> CE stays 0, RSP_VALID rises at the next edge, RSP_RES=0, RSP_FLAGS=6'b000001.
REQ-030 Backpressure: RSP_READY=0 for 5 cycles with REQ_VALID=1 -> RSP_VALID and payload stable, REQ_READY=0, CE=0; on RSP_READY=1, return to IDLE and accept the next request on the following edge.
REQ-031 Wrap: preload via 65535 completed transactions, complete one more -> TXN_CNT=16'h0000.
